conv1_sequencer: RTL and testbench

CONV1_SEQUENCER -- requirements
Module: conv1_sequencer

---
 rtl/conv1_sequencer_if.sv | 50 +++++
 rtl/conv1_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_conv1_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1_sequencer_if.sv
// conv1_sequencer_if: bundles every non-clock/reset signal of the conv1 sequencer.
//   master : sequencer side (drives strobes, addresses, datapath controls, status)
//   slave  : environment side (drives start/config, memory read data, datapath valid)
// Signals:
//   start, cfg_base_in, cfg_base_out       frame request and base addresses
//   busy, done, err                        frame status
//   wgt_rd_en/addr/data                    weight memory read port (data 1 cycle later)
//   if_rd_en/addr/data                     ifmap memory read port (data 1 cycle later)
//   dp_en, dp_ifmap, dp_filtr_0/1/2        datapath row and weight feed
//   dp_din_vald, dp_dout_vald              datapath frame-start / result-row valid
//   of_wr_en, of_wr_addr                   ofmap write port
interface conv1_sequencer_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              start;
    logic [ADDR_W-1:0] cfg_base_in;
    logic [ADDR_W-1:0] cfg_base_out;
    logic              busy;
    logic              done;
    logic              err;
    logic              wgt_rd_en;
    logic [1:0]        wgt_rd_addr;
    logic [47:0]       wgt_rd_data;
    logic              if_rd_en;
    logic [ADDR_W-1:0] if_rd_addr;
    logic [207:0]      if_rd_data;
    logic              dp_en;
    logic [207:0]      dp_ifmap;
    logic [47:0]       dp_filtr_0;
    logic [47:0]       dp_filtr_1;
    logic [47:0]       dp_filtr_2;
    logic              dp_din_vald;
    logic              dp_dout_vald;
    logic              of_wr_en;
    logic [ADDR_W-1:0] of_wr_addr;

    modport master (
        input  start, cfg_base_in, cfg_base_out, wgt_rd_data, if_rd_data, dp_dout_vald,
        output busy, done, err, wgt_rd_en, wgt_rd_addr, if_rd_en, if_rd_addr,
               dp_en, dp_ifmap, dp_filtr_0, dp_filtr_1, dp_filtr_2, dp_din_vald,
               of_wr_en, of_wr_addr
    );

    modport slave (
        output start, cfg_base_in, cfg_base_out, wgt_rd_data, if_rd_data, dp_dout_vald,
        input  busy, done, err, wgt_rd_en, wgt_rd_addr, if_rd_en, if_rd_addr,
               dp_en, dp_ifmap, dp_filtr_0, dp_filtr_1, dp_filtr_2, dp_din_vald,
               of_wr_en, of_wr_addr
    );
endinterface

// File: rtl/conv1_sequencer.sv
// conv1_sequencer: per-frame control for a 3x3 conv layer.
//   Loads three weight words, streams ROWS_IN ifmap rows into the datapath, and writes up to
//   ROWS_OUT result rows to the ofmap, aborting with a sticky err if results stall for TIMEOUT
//   cycles after the last row was read.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - conv1_sequencer_if.master (control, memory ports, datapath feed, status)
module conv1_sequencer #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned ROWS_IN  = 26,
    parameter int unsigned ROWS_OUT = 24,
    parameter int unsigned TIMEOUT  = 64
) (
    input logic               clk,
    input logic               rst,
    conv1_sequencer_if.master bus
);
    localparam int unsigned RD_W = $clog2(ROWS_IN + 1);
    localparam int unsigned WR_W = $clog2(ROWS_OUT + 1);
    localparam int unsigned DR_W = $clog2(TIMEOUT + 1);

    localparam logic [RD_W-1:0] RD_LAST = RD_W'(ROWS_IN - 1);
    localparam logic [WR_W-1:0] WR_FULL = WR_W'(ROWS_OUT);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] base_in_q;
    logic [ADDR_W-1:0] base_out_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              wgt_rd_en_q;
    logic [1:0]        wgt_rd_addr_q;
    logic              wgt_vld_q;
    logic [1:0]        wgt_addr_q;
    logic              if_rd_en_q;
    logic [ADDR_W-1:0] if_rd_addr_q;
    logic              dp_en_q;
    logic              dp_din_vald_q;
    logic [47:0]       filtr_0_q;
    logic [47:0]       filtr_1_q;
    logic [47:0]       filtr_2_q;
    logic [RD_W-1:0]   rd_cnt_q;
    logic [WR_W-1:0]   wr_cnt_q;
    logic [DR_W-1:0]   drain_cnt_q;

    logic            wr_fire;
    logic            accept;
    logic [WR_W-1:0] wr_cnt_nxt;

    always_comb begin
        wr_fire    = bus.dp_dout_vald && (state_q == StStream || state_q == StDrain) &&
                     (wr_cnt_q < WR_FULL);
        wr_cnt_nxt = wr_cnt_q + WR_W'(wr_fire);
        // A held start is also taken in DONE so back-to-back frames abut with no idle gap.
        accept     = bus.start && (state_q == StIdle || state_q == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            base_in_q     <= '0;
            base_out_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            wgt_rd_en_q   <= 1'b0;
            wgt_rd_addr_q <= '0;
            wgt_vld_q     <= 1'b0;
            wgt_addr_q    <= '0;
            if_rd_en_q    <= 1'b0;
            if_rd_addr_q  <= '0;
            dp_en_q       <= 1'b0;
            dp_din_vald_q <= 1'b0;
            filtr_0_q     <= '0;
            filtr_1_q     <= '0;
            filtr_2_q     <= '0;
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
            drain_cnt_q   <= '0;
        end else begin
            // Weight data returns one cycle after its strobe; track which word is arriving.
            wgt_vld_q  <= wgt_rd_en_q;
            wgt_addr_q <= wgt_rd_addr_q;
            if (wgt_vld_q) begin
                case (wgt_addr_q)
                    2'd0:    filtr_0_q <= bus.wgt_rd_data;
                    2'd1:    filtr_1_q <= bus.wgt_rd_data;
                    default: filtr_2_q <= bus.wgt_rd_data;
                endcase
            end

            // Row data is valid the cycle after the read, so dp_en is the delayed read strobe.
            dp_en_q       <= if_rd_en_q;
            dp_din_vald_q <= 1'b0;
            done_q        <= 1'b0;
            if (wr_fire) begin
                wr_cnt_q <= wr_cnt_nxt;
            end

            case (state_q)
                StIdle: ;
                StLoadW: begin
                    if (wgt_rd_addr_q == 2'd2) begin
                        wgt_rd_en_q   <= 1'b0;
                        wgt_rd_addr_q <= '0;
                        if_rd_en_q    <= 1'b1;
                        if_rd_addr_q  <= base_in_q;
                        rd_cnt_q      <= '0;
                        state_q       <= StStream;
                    end else begin
                        wgt_rd_addr_q <= wgt_rd_addr_q + 2'd1;
                    end
                end
                StStream: begin
                    // Row 0 reaches the datapath next cycle, together with dp_en.
                    dp_din_vald_q <= (rd_cnt_q == '0);
                    rd_cnt_q      <= rd_cnt_q + 1'b1;
                    if (rd_cnt_q == RD_LAST) begin
                        if_rd_en_q  <= 1'b0;
                        drain_cnt_q <= '0;
                        state_q     <= StDrain;
                    end else begin
                        if_rd_addr_q <= if_rd_addr_q + 1'b1;
                    end
                end
                StDrain: begin
                    drain_cnt_q <= drain_cnt_q + 1'b1;
                    // A completing write wins over a timeout landing in the same cycle.
                    if (wr_cnt_nxt == WR_FULL) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (drain_cnt_q == DR_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (accept) begin
                base_in_q     <= bus.cfg_base_in;
                base_out_q    <= bus.cfg_base_out;
                err_q         <= 1'b0;
                busy_q        <= 1'b1;
                rd_cnt_q      <= '0;
                wr_cnt_q      <= '0;
                drain_cnt_q   <= '0;
                wgt_rd_en_q   <= 1'b1;
                wgt_rd_addr_q <= '0;
                state_q       <= StLoadW;
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.wgt_rd_en   = wgt_rd_en_q;
    assign bus.wgt_rd_addr = wgt_rd_addr_q;
    assign bus.if_rd_en    = if_rd_en_q;
    assign bus.if_rd_addr  = if_rd_addr_q;
    assign bus.dp_en       = dp_en_q;
    assign bus.dp_ifmap    = bus.if_rd_data;
    assign bus.dp_filtr_0  = filtr_0_q;
    assign bus.dp_filtr_1  = filtr_1_q;
    assign bus.dp_filtr_2  = filtr_2_q;
    assign bus.dp_din_vald = dp_din_vald_q;
    assign bus.of_wr_en    = wr_fire;
    assign bus.of_wr_addr  = base_out_q + ADDR_W'(wr_cnt_q);

endmodule

// File: tb/tb_conv1_sequencer.sv
// tb_conv1_sequencer: directed bench for conv1_sequencer.
//   Weight/ifmap memories with one-cycle read latency, and a datapath model whose first
//   result appears 5 cycles after row 2 and then emits a programmable number of
//   back-to-back result pulses. Table of frame vectors plus hand-written reset and
//   back-to-back sequences.
module tb_conv1_sequencer;
    logic clk;
    logic rst;

    conv1_sequencer_if #(.ADDR_W(10)) bus ();

    conv1_sequencer #(
        .ADDR_W  (10),
        .ROWS_IN (26),
        .ROWS_OUT(24),
        .TIMEOUT (64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memories and datapath model ----------------
    logic [47:0] wgt_mem [0:3];
    int          pulses_total;
    logic [3:0]  sh;
    int          row_idx;
    int          left;

    function automatic logic [207:0] row_of(input logic [9:0] a);
        logic [207:0] r;
        for (int i = 0; i < 26; i++) r[i*8 +: 8] = 8'(a + 10'(3 * i));
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.wgt_rd_en) bus.wgt_rd_data <= wgt_mem[bus.wgt_rd_addr];
        if (bus.if_rd_en)  bus.if_rd_data  <= row_of(bus.if_rd_addr);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sh      <= '0;
            row_idx <= 0;
            left    <= 0;
        end else begin
            row_idx <= bus.dp_en ? row_idx + 1 : 0;
            sh      <= {sh[2:0], bus.dp_en && row_idx == 2};
            if (sh[3])         left <= pulses_total;
            else if (left > 0) left <= left - 1;
        end
    end

    assign bus.dp_dout_vald = (left > 0);

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [207:0] act, input logic [207:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [9:0]   rd_q[$];
    logic [9:0]   wr_q[$];
    logic [1:0]   wg_q[$];
    int           din_cnt, dpen_cnt, busy_cnt, done_cnt, viol, ncyc, drain_at, done_at;
    logic         err_at_done, busy_at_done, prev_rd;
    logic [207:0] din_row;

    task automatic clear_mon();
        rd_q.delete();
        wr_q.delete();
        wg_q.delete();
        din_cnt = 0; dpen_cnt = 0; busy_cnt = 0; done_cnt = 0; viol = 0; ncyc = 0;
        drain_at = -1000; done_at = 0; err_at_done = 1'bx; busy_at_done = 1'bx;
        prev_rd = 1'b0; din_row = '0;
    endtask

    // Called once per negedge while a frame is being observed.
    task automatic sample();
        ncyc++;
        if (bus.if_rd_en)  rd_q.push_back(bus.if_rd_addr);
        if (bus.wgt_rd_en) wg_q.push_back(bus.wgt_rd_addr);
        if (bus.of_wr_en)  wr_q.push_back(bus.of_wr_addr);
        if (bus.dp_din_vald) begin
            din_cnt++;
            din_row = bus.dp_ifmap;
        end
        if (bus.dp_en) dpen_cnt++;
        if (bus.busy)  busy_cnt++;
        if (bus.done) begin
            done_cnt++;
            done_at      = ncyc;
            err_at_done  = bus.err;
            busy_at_done = bus.busy;
        end
        if (prev_rd && !bus.if_rd_en) drain_at = ncyc;
        prev_rd = bus.if_rd_en;
        if ((bus.of_wr_en && !bus.busy) || (bus.if_rd_en && bus.wgt_rd_en) ||
            (bus.dp_din_vald && !bus.dp_en)) viol++;
    endtask

    task automatic wait_done(input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            sample();
            if (bus.done) seen = 1'b1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".flags"}, {bus.busy, bus.done, bus.err, bus.wgt_rd_en, bus.if_rd_en,
                              bus.dp_en, bus.dp_din_vald, bus.of_wr_en}, 0);
        chk({tag, ".addrs"}, {bus.if_rd_addr, bus.wgt_rd_addr, bus.of_wr_addr}, 0);
        chk({tag, ".filtr"}, {bus.dp_filtr_0, bus.dp_filtr_1, bus.dp_filtr_2}, 0);
    endtask

    typedef struct {
        string       name;
        logic [9:0]  base_in;
        logic [9:0]  base_out;
        int          pulses;
        logic [47:0] w0, w1, w2;
        logic [9:0]  exp_first_rd;
        logic [9:0]  exp_last_rd;
        int          exp_writes;
        logic [9:0]  exp_last_wr;
        logic        exp_err;
        int          exp_drain;   // cycles from DRAIN entry to the done pulse
    } vec_t;

    task automatic run_vec(input vec_t v);
        bit seen;
        int bad;
        wgt_mem[0] = v.w0; wgt_mem[1] = v.w1; wgt_mem[2] = v.w2;
        pulses_total = v.pulses;
        @(negedge clk);
        clear_mon();
        bus.cfg_base_in  = v.base_in;
        bus.cfg_base_out = v.base_out;
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        sample();
        wait_done(400, seen);
        chk({v.name, ".done_seen"}, seen, 1);
        repeat (10) begin
            @(negedge clk);
            sample();
        end
        chk({v.name, ".rd_n"}, rd_q.size(), 26);
        chk({v.name, ".rd_first"}, rd_q[0], v.exp_first_rd);
        chk({v.name, ".rd_last"}, rd_q[rd_q.size()-1], v.exp_last_rd);
        bad = 0;
        foreach (rd_q[k]) if (rd_q[k] !== 10'(v.base_in + 10'(k))) bad++;
        chk({v.name, ".rd_seq_bad"}, bad, 0);
        chk({v.name, ".wr_n"}, wr_q.size(), v.exp_writes);
        chk({v.name, ".wr_last"}, wr_q[wr_q.size()-1], v.exp_last_wr);
        bad = 0;
        foreach (wr_q[k]) if (wr_q[k] !== 10'(v.base_out + 10'(k))) bad++;
        chk({v.name, ".wr_seq_bad"}, bad, 0);
        chk({v.name, ".wgt_seq"}, {wg_q.size(), wg_q[0], wg_q[1], wg_q[2]},
            {32'd3, 2'd0, 2'd1, 2'd2});
        chk({v.name, ".filtr_0"}, bus.dp_filtr_0, v.w0);
        chk({v.name, ".filtr_1"}, bus.dp_filtr_1, v.w1);
        chk({v.name, ".filtr_2"}, bus.dp_filtr_2, v.w2);
        chk({v.name, ".din_cnt"}, din_cnt, 1);
        chk({v.name, ".din_row"}, din_row, row_of(v.base_in));
        chk({v.name, ".dpen_cnt"}, dpen_cnt, 26);
        chk({v.name, ".done_cnt"}, done_cnt, 1);
        chk({v.name, ".busy_at_done"}, busy_at_done, 0);
        chk({v.name, ".err_at_done"}, err_at_done, v.exp_err);
        chk({v.name, ".err_sticky"}, bus.err, v.exp_err);
        chk({v.name, ".drain_to_done"}, done_at - drain_at, v.exp_drain);
        chk({v.name, ".busy_cycles"}, busy_cnt, 3 + 26 + v.exp_drain);
        chk({v.name, ".violations"}, viol, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        bit   seen;

        vecs[0] = '{"nominal", 10'h100, 10'h200, 24, 48'hA0A1_A2A3_A4A5, 48'hB0B1_B2B3_B4B5,
                    48'hC0C1_C2C3_C4C5, 10'h100, 10'h119, 24, 10'h217, 1'b0, 6};
        vecs[1] = '{"timeout", 10'h100, 10'h200, 10, 48'h1111_2222_3333, 48'h4444_5555_6666,
                    48'h7777_8888_9999, 10'h100, 10'h119, 10, 10'h209, 1'b1, 64};
        vecs[2] = '{"excess", 10'h040, 10'h300, 30, 48'hDEAD_BEEF_0001, 48'hCAFE_F00D_0002,
                    48'h0123_4567_89AB, 10'h040, 10'h059, 24, 10'h317, 1'b0, 6};
        vecs[3] = '{"wrap", 10'h3F0, 10'h3F8, 24, 48'hFFFF_0000_FFFF, 48'h0000_FFFF_0000,
                    48'h5A5A_A5A5_5A5A, 10'h3F0, 10'h009, 24, 10'h00F, 1'b0, 6};

        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.cfg_base_in  = '0;
        bus.cfg_base_out = '0;
        pulses_total     = 24;
        clear_mon();
        @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Mid-frame reset at STREAM row 12.
        pulses_total = 24;
        @(negedge clk);
        clear_mon();
        bus.cfg_base_in  = 10'h100;
        bus.cfg_base_out = 10'h200;
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        sample();
        for (int i = 0; i < 100 && rd_q.size() < 13; i++) begin
            @(negedge clk);
            sample();
        end
        chk("midrst.row12_addr", rd_q[rd_q.size()-1], 10'h10C);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        repeat (3) begin
            @(negedge clk);
            sample();
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            sample();
        end
        chk("midrst.no_done", done_cnt, 0);
        chk("midrst.idle_busy", bus.busy, 0);
        vecs[0].name = "post_rst";
        run_vec(vecs[0]);

        // Back-to-back frames with start held, then a stray start pulse while busy.
        pulses_total = 24;
        @(negedge clk);
        clear_mon();
        bus.cfg_base_in  = 10'h100;
        bus.cfg_base_out = 10'h200;
        bus.start        = 1'b1;
        wait_done(400, seen);
        chk("b2b.done1_seen", seen, 1);
        @(negedge clk);
        sample();
        chk("b2b.load_next", {bus.wgt_rd_en, bus.wgt_rd_addr, bus.busy}, 4'b1001);
        bus.start = 1'b0;
        repeat (15) begin
            @(negedge clk);
            sample();
        end
        bus.start = 1'b1;
        @(negedge clk);
        sample();
        bus.start = 1'b0;
        wait_done(400, seen);
        chk("b2b.done2_seen", seen, 1);
        repeat (10) begin
            @(negedge clk);
            sample();
        end
        chk("b2b.done_cnt", done_cnt, 2);
        chk("b2b.rd_n", rd_q.size(), 52);
        chk("b2b.wr_n", wr_q.size(), 48);
        chk("b2b.wgt_n", wg_q.size(), 6);
        chk("b2b.din_cnt", din_cnt, 2);
        chk("b2b.final_busy", bus.busy, 0);
        chk("b2b.violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
